// File: rtl/multiplier_n_if.sv
// Operator-side bundle for the add-shift multiplier: switch/button levels in,
// register views, adder output and completion flag out.
interface multiplier_n_if #(
    parameter int WIDTH = 8
);
    logic             ClearA_LoadB;
    logic             Run;
    logic             Signed_Mode;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Xval;
    logic [WIDTH:0]   Sum;
    logic             Done;

    modport master (
        output ClearA_LoadB, Run, Signed_Mode, SW,
        input  Aval, Bval, Xval, Sum, Done
    );

    modport slave (
        input  ClearA_LoadB, Run, Signed_Mode, SW,
        output Aval, Bval, Xval, Sum, Done
    );
endinterface

// File: rtl/multiplier_n.sv
// WIDTH-bit sequential add-shift multiplier, signed or unsigned per operation.
// Product accumulates in {A,B}; X is the extension/carry bit above A.
module multiplier_n #(
    parameter int WIDTH = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    multiplier_n_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              x_q;
    logic [CW-1:0]     count_q;
    logic              mode_q;
    logic              armed_q;
    logic              start;
    logic              subtract;
    logic signed [WIDTH:0] xa_ext, s_ext, sum;

    // Multiplicand extended to WIDTH+1 bits: sign-extended in signed mode.
    function automatic logic signed [WIDTH:0] ext_s(input logic [WIDTH-1:0] s, input logic sgn);
        ext_s = sgn ? $signed({s[WIDTH-1], s}) : $signed({1'b0, s});
    endfunction

    // In signed mode X always mirrors A's sign outside ADD, so {X,A} equals
    // sext(A); in unsigned mode X is zero there, so {X,A} equals {0,A}.
    assign xa_ext   = $signed({x_q, a_q});
    assign s_ext    = ext_s(bus.SW, mode_q);
    assign subtract = mode_q && (count_q == LAST);
    assign sum      = subtract ? (xa_ext - s_ext) : (xa_ext + s_ext);

    // A start needs Run seen low at least once since reset.
    assign start = bus.Run && armed_q;

    assign bus.Aval = a_q;
    assign bus.Bval = b_q;
    assign bus.Xval = x_q;
    assign bus.Sum  = sum;
    assign bus.Done = (state_q == HOLD);

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLR;
            CLR:     state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = (count_q == LAST) ? HOLD : ADD;
            HOLD:    if (!bus.Run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Start arming: set once Run has been observed low.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)        armed_q <= 1'b0;
        else if (!bus.Run) armed_q <= 1'b1;
    end

    // Datapath registers: load, clear, conditional add and combined shift.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= 1'b0;
            count_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q <= bus.Signed_Mode;
                    end else if (!bus.Run && bus.ClearA_LoadB) begin
                        a_q <= '0;
                        x_q <= 1'b0;
                        b_q <= bus.SW;
                    end
                end
                CLR: begin
                    a_q     <= '0;
                    x_q     <= 1'b0;
                    count_q <= '0;
                end
                ADD: begin
                    if (b_q[0]) {x_q, a_q} <= sum;
                end
                SHIFT: begin
                    x_q     <= mode_q ? x_q : 1'b0;
                    a_q     <= {x_q, a_q[WIDTH-1:1]};
                    b_q     <= {a_q[0], b_q[WIDTH-1:1]};
                    count_q <= count_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplier_n.sv
// Directed bench for multiplier_n: an arithmetic product model plus a
// per-cycle monitor while the outputs are stable, and literal expectations.
module tb_multiplier_n;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    multiplier_n_if #(.WIDTH(8)) bus8 ();
    multiplier_n_if #(.WIDTH(4)) bus4 ();

    multiplier_n #(.WIDTH(8)) dut8 (.Clk(clk), .Reset(rst_n), .bus(bus8.slave));
    multiplier_n #(.WIDTH(4)) dut4 (.Clk(clk), .Reset(rst_n), .bus(bus4.slave));

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_a, exp_b;
    logic         exp_x, exp_done, mode_exp;
    bit           mon_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected adder output: {X,A} plus the mode-extended live switch value.
    function automatic logic [W:0] model_sum();
        logic [W:0] s;
        s = mode_exp ? {bus8.SW[W-1], bus8.SW} : {1'b0, bus8.SW};
        return {exp_x, exp_a} + s;
    endfunction

    // Product model: plain integer multiply of S by the current B.
    task automatic model_mult(input logic [W-1:0] s, input logic sm);
        int p;
        if (sm) p = int'($signed(s)) * int'($signed(exp_b));
        else    p = int'(s) * int'(exp_b);
        exp_a    = p[15:8];
        exp_b    = p[7:0];
        exp_x    = sm ? p[15] : 1'b0;
        mode_exp = sm;
    endtask

    // Monitor: every stable cycle must match the model.
    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_done", bus8.Done, exp_done);
            check("mon_a", bus8.Aval, exp_a);
            check("mon_b", bus8.Bval, exp_b);
            check("mon_x", bus8.Xval, exp_x);
            check("mon_sum", bus8.Sum, model_sum());
        end
    end

    task automatic do_load(input logic [W-1:0] sw);
        mon_on = 1'b0;
        bus8.ClearA_LoadB = 1'b1;
        bus8.SW = sw;
        @(posedge clk); #1;
        bus8.ClearA_LoadB = 1'b0;
        exp_a = '0;
        exp_x = 1'b0;
        exp_b = sw;
        mon_on = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_run(input logic [W-1:0] s, input logic sm, input int hold,
                          input int clr_mid, input bit clr_with_run);
        int n;
        mon_on = 1'b0;
        bus8.SW = s;
        bus8.Signed_Mode = sm;
        bus8.Run = 1'b1;
        bus8.ClearA_LoadB = clr_with_run;
        model_mult(s, sm);
        n = -1;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk); #1;
            bus8.ClearA_LoadB = (e == clr_mid);
            if (bus8.Done) begin
                n = e;
                break;
            end
        end
        bus8.ClearA_LoadB = 1'b0;
        check("latency", n, 2 * W + 1);
        exp_done = 1'b1;
        mon_on = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        mon_on = 1'b0;
        bus8.Run = 1'b0;
        @(posedge clk); #1;
        exp_done = 1'b0;
        mon_on = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int n4;
        rst_n = 1'b0;
        bus8.ClearA_LoadB = 1'b0; bus8.Run = 1'b0; bus8.Signed_Mode = 1'b0; bus8.SW = '0;
        bus4.ClearA_LoadB = 1'b0; bus4.Run = 1'b0; bus4.Signed_Mode = 1'b0; bus4.SW = '0;
        exp_a = '0; exp_b = '0; exp_x = 1'b0; exp_done = 1'b0; mode_exp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ab", {bus8.Aval, bus8.Bval}, 16'h0000);
        check("rst_x", bus8.Xval, 1'b0);
        check("rst_done", bus8.Done, 1'b0);
        rst_n = 1'b1;
        mon_on = 1'b1;
        @(posedge clk); #1;

        // Signed: -1 loaded, times 1.
        do_load(8'hFF);
        check("t1_load_b", bus8.Bval, 8'hFF);
        do_run(8'h01, 1'b1, 1, -1, 1'b0);
        check("t1_ab", {bus8.Aval, bus8.Bval}, 16'hFFFF);
        check("t1_x", bus8.Xval, 1'b1);

        // Chained signed runs multiplying into B.
        do_run(8'hFF, 1'b1, 1, -1, 1'b0);
        check("t2a_ab", {bus8.Aval, bus8.Bval}, 16'h0001);
        do_run(8'h0F, 1'b1, 1, -1, 1'b0);
        check("t2b_ab", {bus8.Aval, bus8.Bval}, 16'h000F);
        do_run(8'hFF, 1'b1, 1, -1, 1'b0);
        check("t2c_ab", {bus8.Aval, bus8.Bval}, 16'hFFF1);

        // Unsigned.
        do_load(8'hFF);
        do_run(8'hFF, 1'b0, 1, -1, 1'b0);
        check("t3a_ab", {bus8.Aval, bus8.Bval}, 16'hFE01);
        check("t3a_x", bus8.Xval, 1'b0);
        do_load(8'h80);
        do_run(8'h80, 1'b0, 1, -1, 1'b0);
        check("t3b_ab", {bus8.Aval, bus8.Bval}, 16'h4000);

        // Signed boundary and mixed sign.
        do_load(8'h80);
        do_run(8'h80, 1'b1, 1, -1, 1'b0);
        check("t4a_ab", {bus8.Aval, bus8.Bval}, 16'h4000);
        do_load(8'hFD);
        do_run(8'h07, 1'b1, 1, -1, 1'b0);
        check("t4b_ab", {bus8.Aval, bus8.Bval}, 16'hFFEB);

        // Zero operands.
        do_load(8'h00);
        do_run(8'h5A, 1'b1, 1, -1, 1'b0);
        check("zero_b", {bus8.Aval, bus8.Bval}, 16'h0000);
        do_load(8'h37);
        do_run(8'h00, 1'b0, 1, -1, 1'b0);
        check("zero_s", {bus8.Aval, bus8.Bval}, 16'h0000);

        // Run held high for 60 cycles: one multiply, outputs frozen.
        do_load(8'h0C);
        do_run(8'h0B, 1'b0, 60, -1, 1'b0);
        check("hold_ab", {bus8.Aval, bus8.Bval}, 16'h0084);

        // ClearA_LoadB pulsed while in ADD is ignored.
        do_load(8'h06);
        do_run(8'h07, 1'b0, 1, 3, 1'b0);
        check("clr_mid_ab", {bus8.Aval, bus8.Bval}, 16'h002A);

        // Run together with ClearA_LoadB: multiply starts, B not reloaded.
        do_load(8'h03);
        do_run(8'h05, 1'b1, 1, -1, 1'b1);
        check("run_clr_ab", {bus8.Aval, bus8.Bval}, 16'h000F);

        // Reset mid-operation, then Run kept high must not restart.
        do_load(8'h33);
        mon_on = 1'b0;
        bus8.SW = 8'h55;
        bus8.Signed_Mode = 1'b0;
        bus8.Run = 1'b1;
        for (int e = 0; e <= 5; e++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ab", {bus8.Aval, bus8.Bval}, 16'h0000);
        check("rst_mid_x", bus8.Xval, 1'b0);
        check("rst_mid_done", bus8.Done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_a = '0; exp_b = '0; exp_x = 1'b0; exp_done = 1'b0; mode_exp = 1'b0;
        mon_on = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
        end
        bus8.Run = 1'b0;
        @(posedge clk); #1;
        mon_on = 1'b0;

        // WIDTH=4 signed: -3 * 5.
        bus4.ClearA_LoadB = 1'b1;
        bus4.SW = 4'hD;
        @(posedge clk); #1;
        bus4.ClearA_LoadB = 1'b0;
        check("w4_load_b", bus4.Bval, 4'hD);
        bus4.SW = 4'h5;
        bus4.Signed_Mode = 1'b1;
        bus4.Run = 1'b1;
        n4 = -1;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            if (bus4.Done) begin
                n4 = e;
                break;
            end
        end
        check("w4_latency", n4, 9);
        check("w4_ab", {bus4.Aval, bus4.Bval}, 8'hF1);
        check("w4_x", bus4.Xval, 1'b1);
        bus4.Run = 1'b0;
        @(posedge clk); #1;
        check("w4_idle_done", bus4.Done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multiplier_n.md
Name: multiplier_n

Overview:
- Parametrised successor to the lab's 8-bit add-shift multiplier.
- Multiplies switch operand S by register B, WIDTH bits each, in signed (two's-complement) or unsigned mode, selected per operation.
- Product lands in {A,B}, 2*WIDTH bits, and a Done flag marks completion.
- Sits between the board switch/button synchronisers and the hex-display drivers; consecutive Run presses multiply into the previous low half (B).

Parameters:
- WIDTH, 8: operand width in bits; legal range 4..16.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-low; clears all state.
- ClearA_LoadB  in  1  active-high, synchronous level; in IDLE clears A and X and loads B from SW.
- Run  in  1  active-high, synchronous level; starts one multiply per assertion.
- Signed_Mode  in  1  1 = two's-complement, 0 = unsigned; sampled on the start edge.
- SW  in  WIDTH  multiplicand S.
- Aval  out  WIDTH  A register, the product high half.
- Bval  out  WIDTH  B register, the product low half.
- Xval  out  1  extension/carry bit X.
- Sum  out  WIDTH+1  combinational adder output, {X,A} +/- ext(S).
- Done  out  1  high while in HOLD.

Behaviour:
- Reset low (async): A=0, B=0, X=0, count=0, mode latch=0, Done=0, state=IDLE.
- States: IDLE, CLR, ADD, SHIFT, HOLD.
- IDLE:
  - Run=1 → CLR, and latch Signed_Mode.
  - Run=0 and ClearA_LoadB=1 → A=0, X=0, B=SW; stay in IDLE.
  - Run has priority over ClearA_LoadB.
- CLR: A=0, X=0, count=0; B is kept; → ADD.
- ADD, on count k:
  - B[0]=0: A and X unchanged.
  - B[0]=1, signed mode, k=WIDTH-1: {X,A} = sext(A) - sext(S).
  - B[0]=1, signed mode, other k: {X,A} = sext(A) + sext(S).
  - B[0]=1, unsigned mode: {X,A} = {0,A} + {0,S}, so X is the carry out.
  - Then → SHIFT.
- SHIFT: {X,A,B} >> 1.
  - Signed mode: X keeps its value (arithmetic shift).
  - Unsigned mode: X becomes 0.
  - count = count+1; if count was WIDTH-1 → HOLD, else → ADD.
- HOLD: Done=1; registers frozen; Run=0 → IDLE; Run=1 → stay. One multiply per Run assertion.
- Latency: the edge sampling Run=1 is edge 0; Done rises after edge 2*WIDTH+1 (edge 17 for WIDTH=8). Total 2*WIDTH+2 cycles, IDLE to HOLD.
- Signed_Mode and ClearA_LoadB are ignored outside IDLE. SW may change mid-operation, and the adder uses the live SW.
- Sum = {X,A} +/- ext(S) every cycle, regardless of state.
- Arithmetic: WIDTH+1-bit adder; overflow beyond WIDTH+1 bits is impossible by construction.
- Boundaries:
  - Signed S = -2^(WIDTH-1) times B = -2^(WIDTH-1) gives +2^(2*WIDTH-2); this must be correct.
  - S=0 or B=0 gives 0.
- Reset low mid-operation: immediate clear to the reset state. After Reset rises, the FSM sits in IDLE even if Run is held; it needs one cycle of Run=0 before it starts (start is armed only after Run has been seen low).
- Run asserted on the same cycle as ClearA_LoadB in IDLE: multiply starts and B is not reloaded.

Test Plan:
1. WIDTH=8, signed. ClearA_LoadB with SW=FF → B=FF. Then SW=01, Run → A=FF, B=FF, Done=1 at edge 17.
2. Signed, continuing from scenario 1. SW=FF, Run → A=00, B=01; then SW=0F, Run → A=00, B=0F; then SW=FF, Run → A=FF, B=F1.
3. Unsigned. Load B=FF, SW=FF, Run → A=FE, B=01, X=0. Load B=80, SW=80, Run → A=40, B=00.
4. Signed boundary. Load B=80, SW=80, Run → A=40, B=00. Load B=FD, SW=07, Run → A=FF, B=EB.
5. Control:
   - Hold Run=1 for 60 cycles → exactly one multiply; Done stays high and B is unchanged.
   - Pulse ClearA_LoadB during ADD → no effect.
   - Assert Reset at edge 5 of a multiply → A=B=X=0 and Done=0 immediately; no restart while Run stays high.
6. WIDTH=4, signed. Load B=D (-3), SW=5, Run → {A,B}=F1 (-15), with Done after edge 9.
